// File: rtl/apb_regbank_slave.sv
// APB4 register-bank slave: NUM_REGS x DATA_WIDTH registers, programmable wait states, PSLVERR on bad addresses.
// Define APB_SLV_PSTRB_EN to honour PSTRB byte lanes on writes; otherwise every write updates the full word.
module apb_regbank_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [1:0]              dbg_state
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW     = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Handshake: a transfer completes on the rising edge where PSEL, PENABLE and PREADY are all 1;
  // PRDATA and PSLVERR are only meaningful while PREADY is 1 and are driven to 0 otherwise.

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic                  err_q;
  logic                  write_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  addr_err;
  logic [IW-1:0]         addr_idx;

  logic                  setup_phase;
  logic                  access_phase;
  logic                  start;
  logic                  violation;
  logic                  commit;
  logic [IW-1:0]         rd_idx;
  logic                  rd_err;
  logic                  rd_write;

  // Any nonzero low bit or any word index past the bank (upper bits included) is an error.
  always_comb begin
    word_addr = PADDR >> LSB;
    addr_err  = ((PADDR & ADDR_WIDTH'(NBYTES - 1)) != '0) ||
                (word_addr >= ADDR_WIDTH'(NUM_REGS));
    addr_idx  = word_addr[IW-1:0];
  end

  assign setup_phase  = PSEL && !PENABLE;
  assign access_phase = PSEL && PENABLE;

  // Outputs are registered, so the IDLE/DONE state that observes the bus setup phase decides
  // the next state; with no wait states the SETUP step is folded straight into DONE.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    violation  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup_phase)       start     = 1'b1;
        else if (access_phase) violation = 1'b1;
      end
      ST_SETUP, ST_WAIT: begin
        if (!access_phase)         next_state = ST_IDLE;
        else if (cnt == CW'(1))    next_state = ST_DONE;
        else                       next_state = ST_WAIT;
      end
      ST_DONE: begin
        if (setup_phase) start      = 1'b1;
        else             next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (start)     next_state = (WAIT_STATES == 0) ? ST_DONE : ST_SETUP;
    if (violation) next_state = ST_DONE;
  end

  // Transfer attributes carried into the next cycle; a new setup or a violation replaces them.
  always_comb begin
    rd_idx   = idx_q;
    rd_err   = err_q;
    rd_write = write_q;
    if (start) begin
      rd_idx   = addr_idx;
      rd_err   = addr_err;
      rd_write = PWRITE;
    end else if (violation) begin
      rd_err   = 1'b1;
      rd_write = PWRITE;
    end
  end

  assign commit = (state == ST_DONE) && PREADY && access_phase && PWRITE && !err_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state   <= next_state;
      idx_q   <= rd_idx;
      err_q   <= rd_err;
      write_q <= rd_write;
      if (start)
        cnt <= CW'(WAIT_STATES);
      else if (next_state == ST_WAIT || next_state == ST_DONE)
        cnt <= (cnt != '0) ? cnt - CW'(1) : '0;
      else
        cnt <= '0;
      PREADY  <= (next_state == ST_DONE);
      PSLVERR <= (next_state == ST_DONE) && rd_err;
      PRDATA  <= ((next_state == ST_DONE) && !rd_err && !rd_write) ? regs[rd_idx] : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (commit) begin
`ifdef APB_SLV_PSTRB_EN
      for (int b = 0; b < NBYTES; b++)
        if (PSTRB[b]) regs[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
`else
      regs[idx_q] <= PWDATA;
`endif
    end
  end

`ifndef APB_SLV_PSTRB_EN
  // The strobe port stays on the interface but carries no meaning in this build.
  logic unused_pstrb;
  assign unused_pstrb = ^PSTRB;
`endif

  assign dbg_state = state;

endmodule
